// File: rtl/if_stage.sv
// Fetch stage with F/D pipeline register: owns the PC, drives instruction-memory
// address, applies redirects from decode and the exception unit, flags AdEL.
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6ffc,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic        branch_D,
  input  logic        jump_D,
  input  logic        eret_D,
  input  logic [31:0] npc_D,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [4:0]  D_exccode,
  output logic        D_bd,
  output logic        D_valid
);

  logic [31:0] pc;
  logic        fetch_err;

  assign im_addr   = pc;
  assign fetch_err = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  // Priority: reset > req > stall > eret > branch > sequential.
  // A bad PC only poisons the captured word; it never blocks PC advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= PC_RESET;
      D_instr   <= '0;
      D_pc      <= '0;
      D_exccode <= '0;
      D_bd      <= 1'b0;
      D_valid   <= 1'b0;
    end else if (req) begin
      pc        <= EXC_ENTRY;
      D_instr   <= '0;
      D_pc      <= '0;
      D_exccode <= '0;
      D_bd      <= 1'b0;
      D_valid   <= 1'b0;
    end else if (!stall) begin
      if (eret_D) begin
        pc        <= npc_D;
        D_instr   <= '0;
        D_pc      <= '0;
        D_exccode <= '0;
        D_bd      <= 1'b0;
        D_valid   <= 1'b0;
      end else begin
        pc        <= branch_D ? npc_D : pc + 32'd4;
        D_pc      <= pc;
        D_valid   <= 1'b1;
        D_bd      <= jump_D;
        D_instr   <= fetch_err ? 32'd0 : im_rdata;
        D_exccode <= fetch_err ? EXC_ADEL : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each task drives one scenario and compares
// {im_addr, D_instr, D_pc, D_exccode, D_bd, D_valid} against hand-computed values.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, req, stall, branch_D, jump_D, eret_D;
  logic [31:0] npc_D, im_rdata, im_addr, D_instr, D_pc;
  logic [4:0]  D_exccode;
  logic        D_bd, D_valid;

  int checks = 0;
  int failures = 0;

  logic [102:0] obs, e;

  if_stage dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .branch_D(branch_D), .jump_D(jump_D), .eret_D(eret_D),
    .npc_D(npc_D), .im_rdata(im_rdata), .im_addr(im_addr),
    .D_instr(D_instr), .D_pc(D_pc), .D_exccode(D_exccode),
    .D_bd(D_bd), .D_valid(D_valid)
  );

  always #5 clk = ~clk;

  // instruction memory contents: a simple address-derived pattern
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hdead_0000;
  endfunction

  assign im_rdata = ins(im_addr);
  assign obs = {im_addr, D_instr, D_pc, D_exccode, D_bd, D_valid};

  function automatic logic [102:0] ev(input logic [31:0] pc, input logic [31:0] di,
                                      input logic [31:0] dpc, input logic [4:0] ex,
                                      input logic bd, input logic v);
    return {pc, di, dpc, ex, bd, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req = 0; stall = 0; branch_D = 0; jump_D = 0; eret_D = 0; npc_D = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    e = ev(32'h3000, 0, 0, 0, 0, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL reset_state got=%h want=%h", obs, e); end
    reset = 1;
    tick();
    e = ev(32'h3004, ins(32'h3000), 32'h3000, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL seq_3004 got=%h want=%h", obs, e); end
    tick();
    e = ev(32'h3008, ins(32'h3004), 32'h3004, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL seq_3008 got=%h want=%h", obs, e); end
  endtask

  task automatic test_branch();
    tick();  // beq at 0x3008 now in D, PC=0x300c
    e = ev(32'h300c, ins(32'h3008), 32'h3008, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL br_pre got=%h want=%h", obs, e); end
    branch_D = 1; jump_D = 1; npc_D = 32'h3020;
    tick();
    e = ev(32'h3020, ins(32'h300c), 32'h300c, 0, 1, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL br_slot got=%h want=%h", obs, e); end
    idle_inputs();
    tick();
    e = ev(32'h3024, ins(32'h3020), 32'h3020, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL br_target got=%h want=%h", obs, e); end
  endtask

  task automatic test_stall();
    branch_D = 1; jump_D = 1; npc_D = 32'h3010;
    tick();
    idle_inputs();
    e = ev(32'h3010, ins(32'h3024), 32'h3024, 0, 1, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL stall_pre got=%h want=%h", obs, e); end
    stall = 1; branch_D = 1; jump_D = 1; eret_D = 0; npc_D = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs !== e) begin failures++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, e); end
    end
    idle_inputs();
    tick();
    e = ev(32'h3014, ins(32'h3010), 32'h3010, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL stall_resume got=%h want=%h", obs, e); end
  endtask

  task automatic test_adel();
    branch_D = 1; jump_D = 1; npc_D = 32'h3001;
    tick(); idle_inputs();
    tick();
    e = ev(32'h3005, 0, 32'h3001, 5'd4, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL adel_misalign got=%h want=%h", obs, e); end
    branch_D = 1; jump_D = 1; npc_D = 32'h2ffc;
    tick();
    e = ev(32'h2ffc, 0, 32'h3005, 5'd4, 1, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL adel_slot got=%h want=%h", obs, e); end
    idle_inputs();
    tick();
    e = ev(32'h3000, 0, 32'h2ffc, 5'd4, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL adel_low got=%h want=%h", obs, e); end
    branch_D = 1; jump_D = 1; npc_D = 32'h7000;
    tick(); idle_inputs();
    tick();
    e = ev(32'h7004, 0, 32'h7000, 5'd4, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL adel_high got=%h want=%h", obs, e); end
    branch_D = 1; jump_D = 1; npc_D = 32'h6ffc;
    tick(); idle_inputs();
    tick();
    e = ev(32'h7000, ins(32'h6ffc), 32'h6ffc, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL hi_legal got=%h want=%h", obs, e); end
    branch_D = 1; jump_D = 0; npc_D = 32'hffff_fffc;
    tick(); idle_inputs();
    tick();
    e = ev(32'h0000_0000, 0, 32'hffff_fffc, 5'd4, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL pc_wrap got=%h want=%h", obs, e); end
  endtask

  task automatic test_exception();
    req = 1; stall = 1;
    tick();
    idle_inputs();
    e = ev(32'h4180, 0, 0, 0, 0, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL req_over_stall got=%h want=%h", obs, e); end
    eret_D = 1; npc_D = 32'h3040;
    tick();
    idle_inputs();
    e = ev(32'h3040, 0, 0, 0, 0, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL eret_bubble got=%h want=%h", obs, e); end
    tick();
    e = ev(32'h3044, ins(32'h3040), 32'h3040, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL eret_target got=%h want=%h", obs, e); end
  endtask

  task automatic test_reset_vs_req();
    reset = 0; req = 1;
    tick();
    idle_inputs(); reset = 1;
    e = ev(32'h3000, 0, 0, 0, 0, 0);
    checks++; if (obs !== e) begin failures++; $display("FAIL reset_over_req got=%h want=%h", obs, e); end
    tick();
    e = ev(32'h3004, ins(32'h3000), 32'h3000, 0, 0, 1);
    checks++; if (obs !== e) begin failures++; $display("FAIL post_reset got=%h want=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_adel();
    test_exception();
    test_reset_vs_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
